// File: rtl/ra_writer_if.sv
// ra_writer_if -- VRAM write bus used by the region-array writer.
//
// Signals:
//   ra_vram_wr    write request (held until accepted)
//   ra_vram_addr  24-bit write byte address
//   ra_vram_dout  32-bit write data
//   ra_vram_wait  stall from the memory side; a write completes on a
//                 cycle with ra_vram_wr=1 and ra_vram_wait=0
//
// Modports:
//   master  the writer (drives request, address, data)
//   slave   the memory side (drives wait)
interface ra_writer_if;
    logic        ra_vram_wr;
    logic [23:0] ra_vram_addr;
    logic [31:0] ra_vram_dout;
    logic        ra_vram_wait;

    modport master (
        output ra_vram_wr,
        output ra_vram_addr,
        output ra_vram_dout,
        input  ra_vram_wait
    );

    modport slave (
        input  ra_vram_wr,
        input  ra_vram_addr,
        input  ra_vram_dout,
        output ra_vram_wait
    );
endinterface

// File: rtl/ra_writer.sv
// ra_writer -- builds one complete region array in VRAM per ra_start.
//
// For every tile (X inner, Y outer) it writes a control word followed by
// one object-list pointer per list type: opaque, opaque_mod, trans,
// trans_mod and, in fmt v2 only, puncht. Words go out on the vram bus
// at consecutive addresses starting at REGION_BASE[23:0].
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   ra_start                  one-cycle request (honoured only when idle)
//   FPU_PARAM_CFG             bit21 selects fmt v2 (6-word entries)
//   REGION_BASE               byte address of first entry (bits[23:0])
//   tile_max_x, tile_max_y    last tile index in X and Y
//   list_en                   per-type pointer enable
//   ol_base                   byte address of first object-list block
//   zclear_en, flush_en       copied into every control word
//   vram                      write bus (master side)
//   ra_busy, ra_done          array in progress / one-cycle completion
module ra_writer #(
    parameter int unsigned OL_BLOCK_BYTES = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ra_start,
    input  logic [31:0] FPU_PARAM_CFG,
    input  logic [31:0] REGION_BASE,
    input  logic [5:0]  tile_max_x,
    input  logic [5:0]  tile_max_y,
    input  logic [4:0]  list_en,
    input  logic [23:0] ol_base,
    input  logic        zclear_en,
    input  logic        flush_en,
    ra_writer_if.master vram,
    output logic        ra_busy,
    output logic        ra_done
);

    localparam logic [23:0] BLK = 24'(OL_BLOCK_BYTES);

    typedef enum logic [3:0] {
        IDLE, CTRL, OPQ, OPQM, TRN, TRNM, PT, NEXT, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    // Running pointer: always ol_base + (tile_idx*5 + type)*OL_BLOCK_BYTES
    // for the word currently being presented, so no multiplier is needed.
    logic [23:0] ptr_q, ptr_d;
    logic [5:0]  tx_q, tx_d, ty_q, ty_d;
    logic [5:0]  max_x_q, max_x_d, max_y_q, max_y_d;
    logic [4:0]  list_en_q, list_en_d;
    logic        v2_q, v2_d;
    logic        zclear_q, zclear_d;
    logic        flush_q, flush_d;

    logic        accept;
    logic        last_tile;
    logic [2:0]  list_type;
    logic [31:0] ctrl_word;
    logic [31:0] ptr_word;

    // Config bits that are intentionally not used.
    logic unused_cfg;
    assign unused_cfg = ^{FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0], REGION_BASE[31:24]};

    assign accept    = ~vram.ra_vram_wait;
    assign last_tile = (tx_q == max_x_q) && (ty_q == max_y_q);
    assign ctrl_word = {last_tile, zclear_q, 1'b0, flush_q, 14'd0, ty_q, tx_q, 2'b00};

    always_comb begin
        list_type = 3'd0;
        case (state_q)
            OPQM:    list_type = 3'd1;
            TRN:     list_type = 3'd2;
            TRNM:    list_type = 3'd3;
            PT:      list_type = 3'd4;
            default: list_type = 3'd0;
        endcase
    end

    assign ptr_word = list_en_q[list_type] ? {8'h00, ptr_q} : 32'h8000_0000;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= 24'd0;
            ptr_q     <= 24'd0;
            tx_q      <= 6'd0;
            ty_q      <= 6'd0;
            max_x_q   <= 6'd0;
            max_y_q   <= 6'd0;
            list_en_q <= 5'd0;
            v2_q      <= 1'b0;
            zclear_q  <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ptr_q     <= ptr_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            max_x_q   <= max_x_d;
            max_y_q   <= max_y_d;
            list_en_q <= list_en_d;
            v2_q      <= v2_d;
            zclear_q  <= zclear_d;
            flush_q   <= flush_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        max_x_d   = max_x_q;
        max_y_d   = max_y_q;
        list_en_d = list_en_q;
        v2_d      = v2_q;
        zclear_d  = zclear_q;
        flush_d   = flush_q;

        vram.ra_vram_wr   = 1'b0;
        vram.ra_vram_addr = addr_q;
        vram.ra_vram_dout = 32'd0;
        ra_busy           = 1'b0;
        ra_done           = 1'b0;

        case (state_q)
            IDLE: begin
                if (ra_start) begin
                    max_x_d   = tile_max_x;
                    max_y_d   = tile_max_y;
                    list_en_d = list_en;
                    v2_d      = FPU_PARAM_CFG[21];
                    zclear_d  = zclear_en;
                    flush_d   = flush_en;
                    addr_d    = REGION_BASE[23:0];
                    ptr_d     = ol_base;
                    tx_d      = 6'd0;
                    ty_d      = 6'd0;
                    state_d   = CTRL;
                end
            end

            CTRL: begin
                ra_busy           = 1'b1;
                vram.ra_vram_wr   = 1'b1;
                vram.ra_vram_dout = ctrl_word;
                if (accept) begin
                    addr_d  = addr_q + 24'd4;
                    state_d = OPQ;
                end
            end

            OPQ, OPQM, TRN, TRNM, PT: begin
                ra_busy           = 1'b1;
                vram.ra_vram_wr   = 1'b1;
                vram.ra_vram_dout = ptr_word;
                if (accept) begin
                    addr_d = addr_q + 24'd4;
                    ptr_d  = ptr_q + BLK;
                    case (state_q)
                        OPQ:     state_d = OPQM;
                        OPQM:    state_d = TRN;
                        TRN:     state_d = TRNM;
                        TRNM:    state_d = v2_q ? PT : NEXT;
                        default: state_d = NEXT;
                    endcase
                end
            end

            NEXT: begin
                ra_busy = 1'b1;
                // v1 skips the puncht word but the block stride is still
                // five types per tile, so step over the unused slot.
                if (!v2_q) begin
                    ptr_d = ptr_q + BLK;
                end
                if (last_tile) begin
                    state_d = DONE;
                end else begin
                    if (tx_q == max_x_q) begin
                        tx_d = 6'd0;
                        ty_d = ty_q + 6'd1;
                    end else begin
                        tx_d = tx_q + 6'd1;
                    end
                    state_d = CTRL;
                end
            end

            DONE: begin
                ra_done = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ra_writer.sv
module tb_ra_writer;

    localparam int B = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ra_start = 1'b0;
    logic [31:0] fpu_cfg = 32'd0;
    logic [31:0] region_base = 32'd0;
    logic [5:0]  tile_max_x = 6'd0;
    logic [5:0]  tile_max_y = 6'd0;
    logic [4:0]  list_en = 5'd0;
    logic [23:0] ol_base = 24'd0;
    logic        zclear_en = 1'b0;
    logic        flush_en = 1'b0;
    logic        ra_busy;
    logic        ra_done;

    ra_writer_if vif();

    ra_writer #(.OL_BLOCK_BYTES(B)) dut (
        .clock         (clk),
        .reset_n       (reset_n),
        .ra_start      (ra_start),
        .FPU_PARAM_CFG (fpu_cfg),
        .REGION_BASE   (region_base),
        .tile_max_x    (tile_max_x),
        .tile_max_y    (tile_max_y),
        .list_en       (list_en),
        .ol_base       (ol_base),
        .zclear_en     (zclear_en),
        .flush_en      (flush_en),
        .vram          (vif),
        .ra_busy       (ra_busy),
        .ra_done       (ra_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int wmode = 0;       // 0: no stall, 1: random stall, 2: 3-cycle stall on 2nd write
    int mode_base = 0;
    int stall_n = 0;

    logic [55:0] exp_q[$];   // {addr, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [23:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Reference: walk the grid and emit each tile's words from the rules.
    task automatic model_push(input logic v2, input logic [23:0] base,
                              input int mx, input int my, input logic [4:0] en,
                              input logic [23:0] ol, input logic zc, input logic fl);
        logic [23:0] a;
        logic [31:0] ctrl;
        logic [31:0] p;
        int idx;
        int ntype;
        a = base;
        ntype = v2 ? 5 : 4;
        for (int y = 0; y <= my; y++) begin
            for (int x = 0; x <= mx; x++) begin
                idx  = y * (mx + 1) + x;
                ctrl = 32'd0;
                ctrl[31] = (x == mx) && (y == my);
                ctrl[30] = zc;
                ctrl[28] = fl;
                ctrl = ctrl + 32'(y) * 256 + 32'(x) * 4;
                push_exp(a, ctrl);
                a = a + 24'd4;
                for (int t = 0; t < ntype; t++) begin
                    if (en[t]) p = {8'h00, 24'(32'(ol) + 32'((idx * 5 + t) * B))};
                    else       p = 32'h8000_0000;
                    push_exp(a, p);
                    a = a + 24'd4;
                end
            end
        end
    endtask

    // Stall driver.
    initial begin
        vif.ra_vram_wait = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (wmode)
                1: vif.ra_vram_wait = ($urandom_range(0, 3) == 0);
                2: begin
                    if ((acc_cnt - mode_base) == 1 && stall_n < 3) begin
                        vif.ra_vram_wait = 1'b1;
                        stall_n++;
                    end else begin
                        vif.ra_vram_wait = 1'b0;
                    end
                end
                default: vif.ra_vram_wait = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic        prev_stall;
        logic [23:0] prev_a;
        logic [31:0] prev_d;
        logic [55:0] e;
        prev_stall = 1'b0;
        prev_a = 24'd0;
        prev_d = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_wr_hold", {31'd0, vif.ra_vram_wr}, 32'd1);
                    check("stall_addr_hold", {8'd0, vif.ra_vram_addr}, {8'd0, prev_a});
                    check("stall_data_hold", vif.ra_vram_dout, prev_d);
                end
                if (vif.ra_vram_wr && !vif.ra_vram_wait) begin
                    acc_cnt++;
                    $display("[TB] write addr=%h data=%h", vif.ra_vram_addr, vif.ra_vram_dout);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", {8'd0, vif.ra_vram_addr}, {8'd0, e[55:32]});
                        check("wr_data", vif.ra_vram_dout, e[31:0]);
                    end
                end
                if (ra_done) begin
                    done_cnt++;
                    check("done_queue_empty", exp_q.size(), 32'd0);
                end
                prev_stall = vif.ra_vram_wr && vif.ra_vram_wait;
                prev_a = vif.ra_vram_addr;
                prev_d = vif.ra_vram_dout;
            end
        end
    end

    task automatic drive_cfg(input logic v2, input logic [31:0] base, input int mx, input int my,
                             input logic [4:0] en, input logic [23:0] ol,
                             input logic zc, input logic fl);
        fpu_cfg     = $urandom;
        fpu_cfg[21] = v2;
        region_base = base;
        tile_max_x  = 6'(mx);
        tile_max_y  = 6'(my);
        list_en     = en;
        ol_base     = ol;
        zclear_en   = zc;
        flush_en    = fl;
    endtask

    task automatic scramble_cfg();
        fpu_cfg     = $urandom;
        region_base = $urandom;
        tile_max_x  = 6'($urandom);
        tile_max_y  = 6'($urandom);
        list_en     = 5'($urandom);
        ol_base     = 24'($urandom);
        zclear_en   = 1'($urandom);
        flush_en    = 1'($urandom);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        ra_start = 1'b1;
        @(posedge clk); #1;
        ra_start = 1'b0;
    endtask

    // One full array: expected words must already be queued (or use_model set).
    task automatic run_array(input string tag, input logic v2, input logic [31:0] base,
                             input int mx, input int my, input logic [4:0] en,
                             input logic [23:0] ol, input logic zc, input logic fl,
                             input int mode, input int midstart, input bit use_model);
        int d0;
        int a0;
        int nexp;
        $display("[TB] run %s v2=%0d base=%h grid=%0dx%0d en=%b ol=%h wmode=%0d",
                 tag, v2, base[23:0], mx + 1, my + 1, en, ol, mode);
        drive_cfg(v2, base, mx, my, en, ol, zc, fl);
        if (use_model) model_push(v2, base[23:0], mx, my, en, ol, zc, fl);
        nexp = (mx + 1) * (my + 1) * (v2 ? 6 : 5);
        d0 = done_cnt;
        a0 = acc_cnt;
        mode_base = acc_cnt;
        stall_n = 0;
        wmode = mode;
        pulse_start();
        check("busy_after_start", {31'd0, ra_busy}, 32'd1);
        scramble_cfg();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (i == midstart)     ra_start = 1'b1;
            if (i == midstart + 1) ra_start = 1'b0;
            if (done_cnt != d0) break;
        end
        ra_start = 1'b0;
        wmode = 0;
        check("done_pulses", done_cnt - d0, 32'd1);
        check("write_count", acc_cnt - a0, nexp);
        check("busy_after_done", {31'd0, ra_busy}, 32'd0);
        if (mode == 2) check("stall_cycles", stall_n, 32'd3);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin
        int a0;
        // Reset state.
        @(negedge clk);
        check("rst_wr", {31'd0, vif.ra_vram_wr}, 32'd0);
        check("rst_addr", {8'd0, vif.ra_vram_addr}, 32'd0);
        check("rst_data", vif.ra_vram_dout, 32'd0);
        check("rst_busy", {31'd0, ra_busy}, 32'd0);
        check("rst_done", {31'd0, ra_done}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1x1 v1 directed, literal expectations.
        push_exp(24'h1667C0, 32'hC000_0000);
        push_exp(24'h1667C4, 32'h0010_0000);
        push_exp(24'h1667C8, 32'h8000_0000);
        push_exp(24'h1667CC, 32'h8000_0000);
        push_exp(24'h1667D0, 32'h8000_0000);
        run_array("1x1_v1", 1'b0, 32'h001667C0, 0, 0, 5'b00001, 24'h100000, 1'b1, 1'b0, 0, -1, 1'b0);

        // 2x2 v2, spot values through the model plus a literal cross-check.
        model_push(1'b1, 24'h000000, 1, 1, 5'h1F, 24'h100000, 1'b0, 1'b0);
        check("model_t10_ctrl", exp_q[6][31:0], 32'h0000_0004);
        check("model_t10_opq", exp_q[7][31:0], 32'h0010_00A0);
        check("model_t11_ctrl", exp_q[18][31:0], 32'h8000_0104);
        run_array("2x2_v2", 1'b1, 32'h00000000, 1, 1, 5'h1F, 24'h100000, 1'b0, 1'b0, 0, -1, 1'b0);

        // Stall on second write.
        run_array("stall2", 1'b1, 32'h00012340, 1, 0, 5'h15, 24'h200000, 1'b1, 1'b1, 2, -1, 1'b1);

        // ra_start mid-array.
        run_array("midstart", 1'b0, 32'h00004000, 2, 1, 5'h0A, 24'h080000, 1'b0, 1'b1, 0, 8, 1'b1);

        // Address wrap.
        run_array("wrap", 1'b0, 32'h00FFFFF8, 0, 0, 5'h1F, 24'hFFFFE0, 1'b0, 1'b0, 0, -1, 1'b1);

        // Reset after 7 writes.
        $display("[TB] run reset_mid");
        drive_cfg(1'b1, 32'h00300000, 1, 1, 5'h1F, 24'h000100, 1'b1, 1'b0);
        model_push(1'b1, 24'h300000, 1, 1, 5'h1F, 24'h000100, 1'b1, 1'b0);
        a0 = acc_cnt;
        wmode = 0;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (acc_cnt - a0 >= 7) break;
            @(posedge clk); #1;
        end
        check("reset_reached_7", acc_cnt - a0, 32'd7);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_wr", {31'd0, vif.ra_vram_wr}, 32'd0);
        check("mid_rst_addr", {8'd0, vif.ra_vram_addr}, 32'd0);
        check("mid_rst_data", vif.ra_vram_dout, 32'd0);
        check("mid_rst_busy", {31'd0, ra_busy}, 32'd0);
        check("mid_rst_done", {31'd0, ra_done}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("idle_after_rst_wr", {31'd0, vif.ra_vram_wr}, 32'd0);
        check("idle_after_rst_busy", {31'd0, ra_busy}, 32'd0);
        run_array("after_reset", 1'b1, 32'h00300000, 1, 1, 5'h1F, 24'h000100, 1'b1, 1'b0, 0, -1, 1'b1);

        // Randomized arrays with random stalls.
        for (int r = 0; r < 8; r++) begin
            run_array("random", 1'($urandom), {8'($urandom), 22'($urandom), 2'b00},
                      $urandom_range(0, 3), $urandom_range(0, 3), 5'($urandom),
                      24'($urandom), 1'($urandom), 1'($urandom), 1, -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ra_writer.md
RA_WRITER -- requirements
Module: ra_writer

Interface
REQ-001 Parameter OL_BLOCK_BYTES, default 32, meaning the bytes reserved per object list per tile per list type.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ra_start  input  1  single-cycle request to build one complete region array.
REQ-005 FPU_PARAM_CFG  input  32  bit21=1 selects fmt v2 (6-word entries); bit21=0 selects fmt v1 (5-word entries).
REQ-006 REGION_BASE  input  32  byte address of the first entry; bits[23:0] are used.
REQ-007 tile_max_x, tile_max_y  input  6 each  last tile index in X and Y (grid is (max+1) by (max+1)).
REQ-008 list_en  input  5  per-type enable: bit0 opaque, 1 opaque_mod, 2 trans, 3 trans_mod, 4 puncht.
REQ-009 ol_base  input  24  byte address of the first object-list block.
REQ-010 zclear_en, flush_en  input  1 each  copied into every control word.
REQ-011 ra_vram_wr  output  1  write request.
REQ-012 ra_vram_addr  output  24  write byte address.
REQ-013 ra_vram_dout  output  32  write data.
REQ-014 ra_vram_wait  input  1  stall; a write completes on a cycle with ra_vram_wr=1 and ra_vram_wait=0.
REQ-015 ra_busy  output  1  high from the cycle after an accepted ra_start through the cycle before ra_done.
REQ-016 ra_done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-017 Capture all config inputs on ra_start when idle; ignore ra_start while busy.
REQ-018 States: IDLE, CTRL, OPQ, OPQM, TRN, TRNM, PT, NEXT, DONE; IDLE->CTRL on start; CTRL->OPQ->OPQM->TRN->TRNM on each accepted write.
REQ-019 TRNM->PT on accept if fmt v2, else TRNM->NEXT; PT->NEXT on accept.
REQ-020 NEXT: if the current tile is the last tile, go to DONE, else advance the tile and go to CTRL; DONE pulses ra_done and returns to IDLE.
REQ-021 Tile order: X inner (0..tile_max_x), then Y outer; tile_idx = ty*(tile_max_x+1)+tx.
REQ-022 ra_vram_wr is high in every word state and remains high with stable address and data until the write is accepted.
REQ-023 Address starts at REGION_BASE[23:0] and increases by 4 per accepted write, contiguous across tiles; it wraps modulo 2^24.
REQ-024 Control word layout: bit31 = last tile; bit30 = zclear_en; bit28 = flush_en; [13:8] = ty; [7:2] = tx; all other bits 0.
REQ-025 Pointer for type t (0..4): if list_en[t]=1, {8'h00, ol_base + (tile_idx*5+t)*OL_BLOCK_BYTES mod 2^24}; otherwise 32'h80000000.
REQ-026 The stride of 5 types per tile applies in fmt v1 as well; in v1 the puncht word is not written.
REQ-027 Pointer arithmetic uses a running accumulator of at least 24 bits; a 6x6-bit multiplier in the datapath is not permitted.
REQ-028 tile_max_x=tile_max_y=0 produces exactly one entry, with bit31 of the control word set.

Reset
REQ-029 On assertion of reset_n, in any state: state=IDLE, ra_vram_wr=0, ra_vram_addr=0, ra_vram_dout=0, ra_busy=0, ra_done=0, tile counters=0.
REQ-030 Reset mid-array abandons the array; no further writes occur until a new ra_start after release.

Verification
REQ-031 1x1 grid, v1, zclear_en=1, list_en=5'b00001, ol_base=0x100000, REGION_BASE=0x1667C0 -> 5 writes at 0x1667C0..0x1667D0 with data C0000000, 00100000, 80000000, 80000000, 80000000; then one ra_done.
REQ-032 2x2 grid, v2, list_en=5'h1F, ol_base=0x100000, OL_BLOCK_BYTES=32 -> 24 writes. Tile (1,0): control 0x00000004, opaque pointer 0x001000A0. Tile (1,1): control 0x80000104.
REQ-033 ra_vram_wait held high for 3 cycles on the second write -> address and data remain stable and ra_vram_wr remains high; write sequence unchanged.
REQ-034 ra_start pulsed mid-array -> ignored; write count and data unchanged.
REQ-035 reset_n asserted after 7 writes -> outputs zero next edge; a new ra_start after release restarts from REGION_BASE.
REQ-036 REGION_BASE=0xFFFFF8, 1x1 grid, v1 -> addresses FFFFF8, FFFFFC, 000000, 000004, 000008.
